// File: rtl/fpnew_divsqrt_multi_lane_ctrl.sv
// Issue/retire controller for a bank of iterative div/sqrt units.
// Dispatches to the lowest free unit and retires results in issue order.

package fpnew_pkg;

    typedef enum logic [2:0] {
        FP32,
        FP64,
        FP16,
        FP8,
        FP16ALT
    } fp_format_e;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100,
        ROD = 3'b101,
        DYN = 3'b111
    } roundmode_e;

    typedef enum logic [3:0] {
        FMADD,
        FNMSUB,
        ADD,
        MUL,
        DIV,
        SQRT,
        SGNJ,
        MINMAX,
        CMP,
        CLASSIFY,
        F2F,
        F2I,
        I2F,
        CPKAB,
        CPKCD
    } operation_e;

    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

endpackage

module fpnew_divsqrt_multi_lane_ctrl
    import fpnew_pkg::*;
#(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned NumUnits = 2,
    parameter int unsigned TagWidth = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               in_valid_i,
    output logic                               in_ready_o,
    input  logic [1:0][WIDTH-1:0]              operands_i,
    input  operation_e                         op_i,
    input  roundmode_e                         rnd_mode_i,
    input  fp_format_e                         dst_fmt_i,
    input  logic [TagWidth-1:0]                tag_i,
    input  logic                               mask_i,
    input  logic                               flush_i,
    output logic [NumUnits-1:0]                unit_start_o,
    input  logic [NumUnits-1:0]                unit_ready_i,
    input  logic [NumUnits-1:0]                unit_done_i,
    input  logic [NumUnits-1:0][WIDTH-1:0]     unit_result_i,
    input  logic [NumUnits-1:0][4:0]           unit_status_i,
    output logic                               unit_flush_o,
    output logic [1:0][WIDTH-1:0]              unit_operands_o,
    output logic                               unit_is_div_o,
    output roundmode_e                         unit_rnd_mode_o,
    output fp_format_e                         unit_dst_fmt_o,
    output logic                               out_valid_o,
    input  logic                               out_ready_i,
    output logic [WIDTH-1:0]                   result_o,
    output status_t                            status_o,
    output logic [TagWidth-1:0]                tag_o,
    output logic                               mask_o,
    output logic                               busy_o
);

    localparam int unsigned PW = (NumUnits > 1) ? $clog2(NumUnits) : 1;
    localparam logic [PW-1:0] LastIdx = PW'(NumUnits - 1);

    logic [NumUnits-1:0]                r_busy;
    logic [NumUnits-1:0]                r_done;
    logic [NumUnits-1:0][WIDTH-1:0]     r_res;
    status_t [NumUnits-1:0]             r_stat;
    logic [NumUnits-1:0][TagWidth-1:0]  r_tag;
    logic [NumUnits-1:0]                r_mask;
    logic [NumUnits-1:0][PW-1:0]        r_fifo;
    logic [PW-1:0]                      r_wptr;
    logic [PW-1:0]                      r_rptr;

    logic [NumUnits-1:0]                w_free;
    logic [NumUnits-1:0]                w_start;
    logic [PW-1:0]                      w_grant;
    logic [PW-1:0]                      w_head;
    logic                               w_found;
    logic                               w_accept;
    logic                               w_out_valid;
    logic                               w_retire;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LastIdx) ? '0 : p + 1'b1;
    endfunction

    assign w_free     = ~r_busy & unit_ready_i;
    assign in_ready_o = !flush_i && (|w_free);
    assign w_accept   = in_valid_i && in_ready_o;

    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        for (int u = 0; u < NumUnits; u++) begin
            if (w_free[u] && !w_found) begin
                w_grant = PW'(u);
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_start = '0;
        if (w_accept) begin
            w_start[w_grant] = 1'b1;
        end
    end

    assign unit_start_o    = w_start;
    assign unit_flush_o    = flush_i;
    assign unit_operands_o = operands_i;
    assign unit_is_div_o   = (op_i == DIV);
    assign unit_rnd_mode_o = rnd_mode_i;
    assign unit_dst_fmt_o  = dst_fmt_i;

    // The FIFO head always names the oldest unretired slot.
    assign w_head      = r_fifo[r_rptr];
    assign w_out_valid = r_done[w_head];
    assign w_retire    = w_out_valid && out_ready_i && !flush_i;

    assign out_valid_o = w_out_valid;
    assign result_o    = r_res[w_head];
    assign status_o    = r_stat[w_head];
    assign tag_o       = r_tag[w_head];
    assign mask_o      = r_mask[w_head];
    assign busy_o      = |r_busy;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_busy <= '0;
            r_done <= '0;
            r_res  <= '0;
            r_stat <= '0;
            r_tag  <= '0;
            r_mask <= '0;
            r_fifo <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (flush_i) begin
            r_busy <= '0;
            r_done <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            for (int u = 0; u < NumUnits; u++) begin
                if (unit_done_i[u] && r_busy[u]) begin
                    r_done[u] <= 1'b1;
                    r_res[u]  <= unit_result_i[u];
                    r_stat[u] <= status_t'(unit_status_i[u]);
                end
            end
            if (w_accept) begin
                r_busy[w_grant] <= 1'b1;
                r_tag[w_grant]  <= tag_i;
                r_mask[w_grant] <= mask_i;
                r_fifo[r_wptr]  <= w_grant;
                r_wptr          <= ptr_inc(r_wptr);
            end
            // Granted slot is never busy, so it cannot collide with the head.
            if (w_retire) begin
                r_busy[w_head] <= 1'b0;
                r_done[w_head] <= 1'b0;
                r_rptr         <= ptr_inc(r_rptr);
            end
        end
    end

endmodule

// File: tb/tb_fpnew_divsqrt_multi_lane_ctrl.sv
// Directed bench for the multi-lane div/sqrt controller.
// Expected retirements are queued at issue and checked by a monitor.

module tb_fpnew_divsqrt_multi_lane_ctrl;
    import fpnew_pkg::*;

    logic              clk;
    logic              rst_ni;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [1:0][63:0]  operands_i;
    operation_e        op_i;
    roundmode_e        rnd_mode_i;
    fp_format_e        dst_fmt_i;
    logic [3:0]        tag_i;
    logic              mask_i;
    logic              flush_i;
    logic [1:0]        unit_start_o;
    logic [1:0]        unit_ready_i;
    logic [1:0]        unit_done_i;
    logic [1:0][63:0]  unit_result_i;
    logic [1:0][4:0]   unit_status_i;
    logic              unit_flush_o;
    logic [1:0][63:0]  unit_operands_o;
    logic              unit_is_div_o;
    roundmode_e        unit_rnd_mode_o;
    fp_format_e        unit_dst_fmt_o;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [63:0]       result_o;
    status_t           status_o;
    logic [3:0]        tag_o;
    logic              mask_o;
    logic              busy_o;

    typedef struct {
        logic [3:0]  tag;
        logic [63:0] res;
        logic [4:0]  st;
        logic        mask;
    } exp_t;

    exp_t sb[$];
    int   n_checks;
    int   n_fail;

    fpnew_divsqrt_multi_lane_ctrl #(
        .WIDTH(64),
        .NumUnits(2),
        .TagWidth(4)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_ni),
        .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o),
        .operands_i(operands_i),
        .op_i(op_i),
        .rnd_mode_i(rnd_mode_i),
        .dst_fmt_i(dst_fmt_i),
        .tag_i(tag_i),
        .mask_i(mask_i),
        .flush_i(flush_i),
        .unit_start_o(unit_start_o),
        .unit_ready_i(unit_ready_i),
        .unit_done_i(unit_done_i),
        .unit_result_i(unit_result_i),
        .unit_status_i(unit_status_i),
        .unit_flush_o(unit_flush_o),
        .unit_operands_o(unit_operands_o),
        .unit_is_div_o(unit_is_div_o),
        .unit_rnd_mode_o(unit_rnd_mode_o),
        .unit_dst_fmt_o(unit_dst_fmt_o),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .result_o(result_o),
        .status_o(status_o),
        .tag_o(tag_o),
        .mask_o(mask_o),
        .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_ni && !flush_i && out_valid_o && out_ready_i) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL retire_unexpected actual=tag%0d required=none",
                             tag_o);
                end else begin
                    e = sb.pop_front();
                    if (tag_o !== e.tag || result_o !== e.res ||
                        status_o !== e.st || mask_o !== e.mask) begin
                        n_fail++;
                        $display("FAIL retire actual=tag%0d/%h/%b/%b required=tag%0d/%h/%b/%b",
                                 tag_o, result_o, status_o, mask_o,
                                 e.tag, e.res, e.st, e.mask);
                    end
                end
            end
        end
    endtask

    task automatic expect_ret(input logic [3:0] tg, input logic [63:0] r,
                              input logic [4:0] s, input logic m);
        exp_t e;
        e.tag  = tg;
        e.res  = r;
        e.st   = s;
        e.mask = m;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [3:0] tg, input logic mk,
                         input operation_e op, input int u);
        logic [1:0] oh;
        oh         = '0;
        oh[u]      = 1'b1;
        in_valid_i = 1'b1;
        tag_i      = tg;
        mask_i     = mk;
        op_i       = op;
        #1;
        chk("issue_ready", 64'(in_ready_o), 64'd1);
        chk("issue_start", 64'(unit_start_o), 64'(oh));
        chk("issue_is_div", 64'(unit_is_div_o), 64'(op == DIV));
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
    endtask

    task automatic done(input int u, input logic [63:0] r,
                        input logic [4:0] s);
        unit_done_i[u]   = 1'b1;
        unit_result_i[u] = r;
        unit_status_i[u] = s;
        tick();
        unit_done_i[u]   = 1'b0;
        unit_result_i[u] = 64'hDEADBEEF_DEADBEEF;
        unit_status_i[u] = 5'b11111;
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_ni        = 1'b0;
        in_valid_i    = 1'b0;
        operands_i    = '0;
        op_i          = DIV;
        rnd_mode_i    = RNE;
        dst_fmt_i     = FP64;
        tag_i         = '0;
        mask_i        = 1'b0;
        flush_i       = 1'b0;
        unit_ready_i  = 2'b11;
        unit_done_i   = '0;
        unit_result_i = '0;
        unit_status_i = '0;
        out_ready_i   = 1'b1;
        fork
            monitor();
        join_none

        tick();
        tick();
        chk("rst_in_ready", 64'(in_ready_o), 64'd1);
        chk("rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_start", 64'(unit_start_o), 64'd0);
        chk("rst_result", result_o, 64'd0);
        chk("rst_tag", 64'(tag_o), 64'd0);
        chk("rst_mask", 64'(mask_o), 64'd0);
        chk("rst_status", 64'(status_o), 64'd0);
        unit_ready_i = 2'b00;
        #1;
        chk("rst_ready_follows", 64'(in_ready_o), 64'd0);
        unit_ready_i = 2'b11;
        rst_ni       = 1'b1;
        tick();

        // single op: 1.0 / 2.0 = 0.5
        operands_i[0] = 64'h3FF0000000000000;
        operands_i[1] = 64'h4000000000000000;
        rnd_mode_i    = RDN;
        #1;
        chk("pass_opa", unit_operands_o[0], 64'h3FF0000000000000);
        chk("pass_opb", unit_operands_o[1], 64'h4000000000000000);
        chk("pass_rnd", 64'(unit_rnd_mode_o), 64'(RDN));
        issue(4'd5, 1'b0, DIV, 0);
        expect_ret(4'd5, 64'h3FE0000000000000, 5'b0, 1'b0);
        chk("single_busy", 64'(busy_o), 64'd1);
        repeat (11) tick();
        chk("single_wait", 64'(out_valid_o), 64'd0);
        done(0, 64'h3FE0000000000000, 5'b0);
        chk("single_lat", 64'(out_valid_o), 64'd1);
        tick();
        chk("single_gone", 64'(out_valid_o), 64'd0);
        chk("single_idle", 64'(busy_o), 64'd0);

        // out-of-order completion, in-order retire
        issue(4'd1, 1'b0, DIV, 0);
        issue(4'd2, 1'b1, SQRT, 1);
        expect_ret(4'd1, 64'h3FF8000000000000, 5'b00000, 1'b0);
        expect_ret(4'd2, 64'h4008000000000000, 5'b00001, 1'b1);
        done(1, 64'h4008000000000000, 5'b00001);
        repeat (4) begin
            chk("ooo_hold", 64'(out_valid_o), 64'd0);
            tick();
        end
        done(0, 64'h3FF8000000000000, 5'b00000);
        tick();
        tick();
        chk("ooo_drained", 64'(out_valid_o), 64'd0);
        chk("ooo_idle", 64'(busy_o), 64'd0);

        // full, then reuse of the freed unit
        issue(4'd3, 1'b0, DIV, 0);
        issue(4'd4, 1'b0, DIV, 1);
        expect_ret(4'd3, 64'h0000000000000003, 5'b0, 1'b0);
        expect_ret(4'd4, 64'h0000000000000004, 5'b0, 1'b0);
        in_valid_i = 1'b1;
        #1;
        chk("full_ready", 64'(in_ready_o), 64'd0);
        chk("full_start", 64'(unit_start_o), 64'd0);
        in_valid_i = 1'b0;
        done(0, 64'h0000000000000003, 5'b0);
        chk("full_retire_cycle", 64'(in_ready_o), 64'd0);
        tick();
        issue(4'd6, 1'b0, DIV, 0);
        expect_ret(4'd6, 64'h0000000000000006, 5'b00010, 1'b0);
        done(1, 64'h0000000000000004, 5'b0);
        done(0, 64'h0000000000000006, 5'b00010);
        tick();
        tick();
        chk("full_drained", 64'(out_valid_o), 64'd0);

        // backpressure
        out_ready_i = 1'b0;
        issue(4'd7, 1'b1, DIV, 0);
        expect_ret(4'd7, 64'h7FF0000000000000, 5'b00100, 1'b1);
        done(0, 64'h7FF0000000000000, 5'b00100);
        repeat (10) begin
            chk("bp_valid", 64'(out_valid_o), 64'd1);
            chk("bp_result", result_o, 64'h7FF0000000000000);
            chk("bp_tag", 64'(tag_o), 64'd7);
            tick();
        end
        out_ready_i = 1'b1;
        tick();
        chk("bp_single", 64'(out_valid_o), 64'd0);
        tick();
        chk("bp_idle", 64'(busy_o), 64'd0);

        // flush with one done and one in flight
        out_ready_i = 1'b0;
        issue(4'd8, 1'b0, DIV, 0);
        issue(4'd9, 1'b0, DIV, 1);
        done(0, 64'h1111111111111111, 5'b0);
        chk("fl_pre_valid", 64'(out_valid_o), 64'd1);
        flush_i    = 1'b1;
        in_valid_i = 1'b1;
        #1;
        chk("fl_pass", 64'(unit_flush_o), 64'd1);
        chk("fl_ready", 64'(in_ready_o), 64'd0);
        chk("fl_start", 64'(unit_start_o), 64'd0);
        tick();
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        chk("fl_valid", 64'(out_valid_o), 64'd0);
        chk("fl_busy", 64'(busy_o), 64'd0);
        done(1, 64'h2222222222222222, 5'b0);
        tick();
        chk("fl_late_valid", 64'(out_valid_o), 64'd0);
        chk("fl_late_busy", 64'(busy_o), 64'd0);
        out_ready_i = 1'b1;
        tick();

        // reset mid-operation
        out_ready_i = 1'b0;
        issue(4'd10, 1'b0, SQRT, 0);
        issue(4'd11, 1'b1, DIV, 1);
        done(0, 64'h3333333333333333, 5'b00001);
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        chk("mr_valid", 64'(out_valid_o), 64'd0);
        chk("mr_busy", 64'(busy_o), 64'd0);
        chk("mr_start", 64'(unit_start_o), 64'd0);
        chk("mr_result", result_o, 64'd0);
        chk("mr_tag", 64'(tag_o), 64'd0);
        chk("mr_mask", 64'(mask_o), 64'd0);
        chk("mr_status", 64'(status_o), 64'd0);
        chk("mr_ready", 64'(in_ready_o), 64'd1);
        done(1, 64'h4444444444444444, 5'b0);
        chk("mr_late", 64'(out_valid_o), 64'd0);
        out_ready_i = 1'b1;
        issue(4'd12, 1'b0, DIV, 0);
        expect_ret(4'd12, 64'h3FD0000000000000, 5'b0, 1'b0);
        done(0, 64'h3FD0000000000000, 5'b0);
        tick();
        tick();
        chk("mr_drained", 64'(out_valid_o), 64'd0);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
